csa64_sub_serial: RTL and testbench
===================================

// Module: csa64_sub_serial
// PURPOSE
//  64-bit signed/unsigned subtractor, d = a - b - bin, computed one 4-bit slice per clock.
//  Inverse-direction companion to the parallel carry-select adder.
//  Trades latency for area: a single 4-bit borrow-ripple slice is time-multiplexed across the word.
//  Sits behind a valid/ready request port and drives a valid/ready result port to downstream datapath logic.
// PARAMETERS
//  WIDTH  64  operand/result width; must be a multiple of SLICE
//  SLICE  4   bits processed per cycle
//  NSLICE WIDTH/SLICE (localparam, 16)  cycles per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      block can accept a request
//  a          in   WIDTH  minuend (two's complement)
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  d          out  WIDTH  difference
//  bout       out  1      borrow out; 1 iff unsigned a < b + bin
//  ovf        out  1      signed overflow: (a[W-1]^b[W-1]) & (a[W-1]^raw_d[W-1])
//  zero       out  1      d == 0
// BEHAVIOUR
//  - Reset: FSM=IDLE, in_ready=1, out_valid=0, d=0, bout=0, ovf=0, zero=0; slice index and borrow reg cleared.
//  - States:
//    IDLE: in_ready=1. On in_valid, latch a, b, bin, set idx=0, borrow=bin, go RUN.
//    RUN: in_ready=0. Each cycle, compute slice idx: diff = a_s - b_s - borrow, write d[idx*SLICE +: SLICE], update borrow.
//         After idx==NSLICE-1, go DONE.
//    DONE: out_valid=1. d/bout/ovf/zero stay stable while out_ready=0. On out_ready, go IDLE (out_valid=0 next cycle).
//  - Latency: request accepted at edge t0, out_valid high after edge t0+NSLICE (16 cycles).
//    Throughput is one op per NSLICE+2 cycles minimum.
//  - in_valid while RUN/DONE is ignored and not queued.
//    In DONE with out_ready=1, a new request is not accepted that same cycle (in_ready=0).
//  - Internal d is updated each RUN cycle. The output flags and out_valid are only meaningful in DONE.
//  - Arithmetic: modulo 2^WIDTH. bout = final slice borrow. ovf is computed on the raw (unsaturated) difference.
//    zero is computed on the delivered d.
//  - Asynchronous reset mid-RUN or mid-DONE aborts the operation; all outputs return to reset values immediately.
// CONFIGURATION
//  CSA_SUB_SAT_EN defined: if ovf=1 in DONE, d is clamped. If a[W-1]=0, d = 0x7FFF..FF; else d = 0x8000..00.
//    ovf still reads 1, and zero reflects the clamped d.
//  Not defined: d wraps (raw difference). No clamp logic is synthesized.
// STRUCTURE
//  Shared package csa_pkg: localparams CSA_WIDTH=64 and CSA_SLICE=4; FSM state enum {IDLE, RUN, DONE}.
//  Sub-module sub_slice4: combinational 4-bit borrow-ripple subtractor, ports A, B, Bin, D, Bout.
//  One instance, muxed by idx. The FSM, operand registers, and result register live in the top.
// TESTING
//  1 a=5, b=3, bin=0 -> after 16 cycles: d=2, bout=0, ovf=0, zero=0; out_valid held until out_ready.
//  2 a=0, b=1, bin=0 -> d=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0.
//  3 a=0x8000_0000_0000_0000, b=1 -> ovf=1, bout=0.
//    Without macro: d=0x7FFF_FFFF_FFFF_FFFF. With CSA_SUB_SAT_EN: d=0x8000_0000_0000_0000.
//  4 a=0x10, b=0xF, bin=1 -> d=0, zero=1, bout=0; a=b=0x1234, bin=1 -> d=all ones, bout=1.
//  5 Backpressure and busy: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0.
//    in_valid pulses during RUN are not executed. The next op result matches only its own operands.
//  6 Assert rst_n=0 at RUN slice 7 -> out_valid=0, in_ready=1 immediately.
//    The following op (a=100, b=58) returns d=42 after 16 cycles.

Source files
------------

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared widths and FSM state type for the serial subtractor
package csa_pkg;

    localparam int CSA_WIDTH = 64;
    localparam int CSA_SLICE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_state_t;

endpackage

// File: rtl/sub_slice4.sv
// rtl/sub_slice4.sv - combinational 4-bit borrow-ripple subtractor slice
module sub_slice4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Bin,
    output logic [3:0] D,
    output logic       Bout
);

    logic br;

    // Ripple the borrow LSB to MSB; each bit borrows when a < b + borrow_in
    always_comb begin
        br = Bin;
        D  = '0;
        for (int i = 0; i < 4; i++) begin
            D[i] = A[i] ^ B[i] ^ br;
            br   = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & br);
        end
        Bout = br;
    end

endmodule

// File: rtl/csa64_sub_serial.sv
// rtl/csa64_sub_serial.sv - slice-serial d = a - b - bin with valid/ready ports; optional clamp under CSA_SUB_SAT_EN
module csa64_sub_serial
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int SLICE = CSA_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = $clog2(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    csa_state_t       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDXW-1:0]  idx;
    logic             borrow;

    logic [31:0]      base;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] slice_d;
    logic             slice_bout;
    logic [WIDTH-1:0] d_next;
    logic             ovf_next;
    logic [WIDTH-1:0] d_final;

    assign base = 32'(idx) * 32'(SLICE);

    // Select the current slice of each latched operand
    always_comb begin
        a_s = a_q[base +: SLICE];
        b_s = b_q[base +: SLICE];
    end

    sub_slice4 u_slice (
        .A    (a_s),
        .B    (b_s),
        .Bin  (borrow),
        .D    (slice_d),
        .Bout (slice_bout)
    );

    // Full-word view of d with this cycle's slice merged in; used for the final flags
    always_comb begin
        d_next = d;
        d_next[base +: SLICE] = slice_d;
    end

    assign ovf_next = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ d_next[WIDTH-1]);

`ifdef CSA_SUB_SAT_EN
    // Clamp toward the minuend's sign when the signed result overflowed
    always_comb begin
        d_final = d_next;
        if (ovf_next) begin
            d_final = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign d_final = d_next;
`endif

    // Request/compute/deliver FSM; one slice retires per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            d         <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            borrow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow   <= bin;
                        idx      <= '0;
                        bout     <= 1'b0;
                        ovf      <= 1'b0;
                        zero     <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    d      <= d_next;
                    borrow <= slice_bout;
                    idx    <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        d         <= d_final;
                        bout      <= slice_bout;
                        ovf       <= ovf_next;
                        zero      <= (d_final == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa64_sub_serial.sv
// tb/tb_csa64_sub_serial.sv - directed self-checking bench for csa64_sub_serial
module tb_csa64_sub_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;

    int total = 0;
    int bad   = 0;

    csa64_sub_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [63:0] av, input logic [63:0] bv, input logic binv);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        check("ready_before_req", 64'(in_ready), 64'd1);
        a        = av;
        b        = bv;
        bin      = binv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("busy_after_accept", 64'(in_ready), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd16);
    endtask

    task automatic check_result(input string tag, input logic [63:0] ed, input logic eb,
                                input logic eo, input logic ez);
        check({tag, "_d"},    d,          ed);
        check({tag, "_bout"}, 64'(bout),  64'(eb));
        check({tag, "_ovf"},  64'(ovf),   64'(eo));
        check({tag, "_zero"}, 64'(zero),  64'(ez));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(in_ready),  64'd1);
    endtask

    task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input logic binv, input logic [63:0] ed, input logic eb,
                          input logic eo, input logic ez);
        start_op(av, bv, binv);
        wait_done(tag);
        check_result(tag, ed, eb, eo, ez);
        release_result(tag);
    endtask

    initial begin
        logic [63:0] held_d;
        logic [63:0] exp_sat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        step();
        step();
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_d",         d,              64'd0);
        check("rst_flags",     {61'd0, bout, ovf, zero}, 64'd0);
        rst_n = 1'b1;
        step();

        // Basic subtraction, result held while out_ready low
        start_op(64'd5, 64'd3, 1'b0);
        wait_done("t1");
        check_result("t1", 64'd2, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("t1_hold_valid", 64'(out_valid), 64'd1);
        check("t1_hold_d",     d,              64'd2);
        release_result("t1");

        run_op("t2", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

`ifdef CSA_SUB_SAT_EN
        exp_sat = 64'h8000_0000_0000_0000;
`else
        exp_sat = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
        run_op("t3", 64'h8000_0000_0000_0000, 64'd1, 1'b0, exp_sat, 1'b0, 1'b1, 1'b0);

        run_op("t4a", 64'h10, 64'hF, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1);
        run_op("t4b", 64'h1234, 64'h1234, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

        // Busy pulses are dropped; backpressure keeps outputs frozen
        start_op(64'h1000, 64'h1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 2 || i == 9) begin
                a        = 64'hFFFF;
                b        = 64'h5;
                bin      = 1'b1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0;
        check("t5_valid", 64'(out_valid), 64'd1);
        check_result("t5", 64'hFFF, 1'b0, 1'b0, 1'b0);
        held_d = d;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t5_stall_d",     d,               held_d);
            check("t5_stall_valid", 64'(out_valid),  64'd1);
            check("t5_stall_ready", 64'(in_ready),   64'd0);
        end
        release_result("t5");
        step();
        step();
        check("t5_no_ghost_op", 64'(out_valid), 64'd0);
        check("t5_idle_ready",  64'(in_ready),  64'd1);
        run_op("t5n", 64'd7, 64'd9, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of RUN
        start_op(64'hDEAD, 64'hBEEF, 1'b0);
        for (int i = 0; i < 7; i++) step();
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_ready", 64'(in_ready),  64'd1);
        check("t6_rst_d",     d,              64'd0);
        step();
        rst_n = 1'b1;
        step();
        run_op("t6", 64'd100, 64'd58, 1'b0, 64'd42, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
